// File: rtl/alu_operand_entry.sv
// rtl/alu_operand_entry.sv - key-driven operand A / operand B / ALU control entry with valid/ready output
// Optional clear key: define ALU_OPERAND_ENTRY_CLEAR_EN to add the clear_n port and its debouncer.

// Synchronises, debounces and edge-detects one active-low pushbutton.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             level;
   logic             level_q;
   logic [CNT_W-1:0] cnt;

   // Two-flop synchroniser; idles at released (1) so reset never looks like a press.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
      end
   end

   // Accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         level <= 1'b1;
         cnt   <= '0;
      end else if (sync2 == level) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         level <= sync2;
         cnt   <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Previous debounced level, used to find the 1->0 (press) transition.
   always_ff @(posedge clk) begin
      if (reset) begin
         level_q <= 1'b1;
      end else begin
         level_q <= level;
      end
   end

   assign press = level_q & ~level;

endmodule

module alu_operand_entry #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             key_n,
`ifdef ALU_OPERAND_ENTRY_CLEAR_EN
   input  logic             clear_n,
`endif
   input  logic [WIDTH-1:0] sw_data,
   input  logic [1:0]       sw_op,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [1:0]       alu_ctrl,
   output logic             valid,
   input  logic             ready,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      S_A    = 2'd0,
      S_B    = 2'd1,
      S_OP   = 2'd2,
      S_WAIT = 2'd3
   } state_t;

   state_t cur_state;
   logic   entry_press;
   logic   clear_press;

   key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_entry_key (
      .clk  (clk),
      .reset(reset),
      .key_n(key_n),
      .press(entry_press)
   );

`ifdef ALU_OPERAND_ENTRY_CLEAR_EN
   key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_clear_key (
      .clk  (clk),
      .reset(reset),
      .key_n(clear_n),
      .press(clear_press)
   );
`else
   assign clear_press = 1'b0;
`endif

   // Entry sequencer: each press captures the next field; the triple is held until accepted.
   always_ff @(posedge clk) begin
      if (reset || clear_press) begin
         cur_state <= S_A;
         a         <= '0;
         b         <= '0;
         alu_ctrl  <= '0;
         valid     <= 1'b0;
      end else begin
         case (cur_state)
            S_A: begin
               if (entry_press) begin
                  a         <= sw_data;
                  cur_state <= S_B;
               end
            end
            S_B: begin
               if (entry_press) begin
                  b         <= sw_data;
                  cur_state <= S_OP;
               end
            end
            S_OP: begin
               if (entry_press) begin
                  alu_ctrl  <= sw_op;
                  valid     <= 1'b1;
                  cur_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               // Presses are ignored here; only the transfer moves the sequence on.
               if (valid && ready) begin
                  valid     <= 1'b0;
                  cur_state <= S_A;
               end
            end
            default: begin
               cur_state <= S_A;
               valid     <= 1'b0;
            end
         endcase
      end
   end

   assign state = cur_state;

endmodule
